// File: rtl/simon_input_checker_if.sv
// simon_input_checker_if: handshake between the game state machine and the input checker
interface simon_input_checker_if;
    logic       gen;
    logic [2:0] training_sel;
    logic       testing;
    logic [2:0] testing_sel;
    logic [1:0] train_color;
    logic       input_done;
    logic       input_correct;

    modport master (
        output gen, training_sel, testing, testing_sel,
        input  train_color, input_done, input_correct
    );

    modport slave (
        input  gen, training_sel, testing, testing_sel,
        output train_color, input_done, input_correct
    );
endinterface

// File: rtl/simon_input_checker.sv
// simon_input_checker: stores the generated colour sequence and judges debounced button presses
module simon_input_checker #(
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                        base_clk,
    input  logic                        reset,
    input  logic [3:0]                  buttons,
    simon_input_checker_if.slave        bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ARM, WAIT_PRESS, WAIT_RELEASE, REPORT} state_t;

    logic [3:0]    b_meta, b_sync, db;
    logic [CW-1:0] db_cnt;
    logic [15:0]   lfsr;
    logic [9:0]    seq;
    state_t        state, state_n;
    logic [2:0]    cur_sel, cur_sel_n;
    logic          hit, hit_n;
    logic [1:0]    db_idx;
    logic          press_ok;

    function automatic logic [1:0] pick(input logic [9:0] s, input logic [2:0] i);
        return i == 3'd0 ? s[1:0] :
               i == 3'd1 ? s[3:2] :
               i == 3'd2 ? s[5:4] :
               i == 3'd3 ? s[7:6] :
               i == 3'd4 ? s[9:8] : 2'd0;
    endfunction

    // The counter restarts whenever the synchronizer is about to change, so only a
    // vector that has held still for DEBOUNCE_CYCLES cycles is promoted to db.
    always_ff @(posedge base_clk or posedge reset) begin
        if (reset) begin
            b_meta <= '0;
            b_sync <= '0;
            db     <= '0;
            db_cnt <= '0;
        end else begin
            b_meta <= buttons;
            b_sync <= b_meta;
            if (b_meta != b_sync || b_sync == db)
                db_cnt <= '0;
            else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db     <= b_sync;
                db_cnt <= '0;
            end else
                db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge base_clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
            seq  <= '0;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            if (bus.gen)
                seq <= lfsr[9:0];
        end
    end

    assign bus.train_color = pick(seq, bus.training_sel);
    assign db_idx          = {db[3] | db[2], db[3] | db[1]};
    assign press_ok        = $onehot(db) && db_idx == pick(seq, cur_sel) && cur_sel <= 3'd4;

    always_comb begin
        state_n   = state;
        cur_sel_n = cur_sel;
        hit_n     = hit;
        if (!bus.testing)
            state_n = IDLE;
        else
            case (state)
                IDLE: begin
                    state_n   = ARM;
                    cur_sel_n = bus.testing_sel;
                end
                ARM:          state_n = db == '0 ? WAIT_PRESS : ARM;
                WAIT_PRESS: if (db != '0) begin
                    hit_n   = press_ok;
                    state_n = WAIT_RELEASE;
                end
                WAIT_RELEASE: state_n = db == '0 ? REPORT : WAIT_RELEASE;
                REPORT: if (bus.testing_sel != cur_sel) begin
                    cur_sel_n = bus.testing_sel;
                    state_n   = ARM;
                end
                default:      state_n = IDLE;
            endcase
    end

    always_ff @(posedge base_clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            cur_sel           <= '0;
            hit               <= 1'b0;
            bus.input_done    <= 1'b0;
            bus.input_correct <= 1'b0;
        end else begin
            state             <= state_n;
            cur_sel           <= cur_sel_n;
            hit               <= hit_n;
            bus.input_done    <= state_n == REPORT;
            bus.input_correct <= state_n == REPORT && hit_n;
        end
    end
endmodule

// File: tb/tb_simon_input_checker.sv
// tb_simon_input_checker: directed scoreboard bench for the Simon input checker
module tb_simon_input_checker;
    logic       base_clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] buttons = 4'h0;
    int         vectors = 0;
    int         miscompares = 0;
    int         lat;
    logic [3:0] exp_q[$];
    logic [15:0] m_lfsr;
    logic [9:0]  m_seq;

    simon_input_checker_if bus();

    simon_input_checker #(.DEBOUNCE_CYCLES(4), .LFSR_SEED(16'hACE1)) dut (
        .base_clk(base_clk),
        .reset(reset),
        .buttons(buttons),
        .bus(bus)
    );

    always #5 base_clk = ~base_clk;

    // Reference sequence: 16-bit Fibonacci LFSR, taps 16,14,13,11, sampled on gen.
    always @(posedge base_clk or posedge reset) begin
        if (reset) begin
            m_lfsr <= 16'hACE1;
            m_seq  <= '0;
        end else begin
            m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
            if (bus.gen)
                m_seq <= m_lfsr[9:0];
        end
    end

    function automatic logic [1:0] col(input int i);
        return m_seq[2*i +: 2];
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge base_clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_next(input string tag, input logic [3:0] obs);
        logic [3:0] e;
        e = exp_q.size() != 0 ? exp_q.pop_front() : 4'hx;
        chk(tag, obs, e);
    endtask

    task automatic press(input logic [3:0] b, input logic exp_correct, input string tag, output int k);
        exp_q.push_back(4'(exp_correct));
        buttons = b;
        tick(10);
        buttons = 4'h0;
        k = 0;
        while (bus.input_done !== 1'b1 && k < 60) begin
            tick(1);
            k++;
        end
        chk({tag, "_done"}, 4'(bus.input_done), 4'h1);
        check_next({tag, "_correct"}, 4'(bus.input_correct));
    endtask

    initial begin
        bus.gen = 1'b0;
        bus.testing = 1'b0;
        bus.testing_sel = 3'd0;
        bus.training_sel = 3'd0;
        buttons = 4'b0010;
        tick(3);
        chk("rst_done", 4'(bus.input_done), 4'h0);
        chk("rst_correct", 4'(bus.input_correct), 4'h0);
        chk("rst_color", 4'(bus.train_color), 4'h0);
        reset = 1'b0;
        tick(20);
        chk("idle_done", 4'(bus.input_done), 4'h0);
        buttons = 4'h0;
        tick(10);

        bus.gen = 1'b1;
        tick(1);
        bus.gen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.training_sel = 3'(i);
            exp_q.push_back(i < 5 ? 4'(col(i)) : 4'h0);
            #1;
            check_next($sformatf("train%0d", i), 4'(bus.train_color));
        end

        bus.testing = 1'b1;
        bus.testing_sel = 3'd0;
        tick(3);
        press(oh(col(0)), 1'b1, "correct0", lat);
        chk("latency", 4'(lat), 4'd7);
        tick(100);
        chk("hold_done", 4'(bus.input_done), 4'h1);
        chk("hold_correct", 4'(bus.input_correct), 4'h1);
        bus.testing_sel = 3'd1;
        tick(1);
        chk("sel_change_done", 4'(bus.input_done), 4'h0);

        tick(2);
        press(oh(2'(col(1) + 2'd1)), 1'b0, "wrong1", lat);
        buttons = oh(col(2));
        tick(10);
        bus.testing_sel = 3'd2;
        tick(1);
        chk("carry_done", 4'(bus.input_done), 4'h0);
        tick(10);
        buttons = 4'h0;
        tick(20);
        chk("carry_ignored", 4'(bus.input_done), 4'h0);
        press(oh(col(2)), 1'b1, "correct2", lat);

        bus.testing_sel = 3'd3;
        tick(3);
        press(4'b0011, 1'b0, "multi3", lat);

        bus.testing_sel = 3'd4;
        tick(1);
        chk("sel4_done", 4'(bus.input_done), 4'h0);
        buttons = oh(col(4));
        tick(2);
        buttons = 4'h0;
        tick(30);
        chk("bounce_done", 4'(bus.input_done), 4'h0);
        press(oh(col(4)), 1'b1, "correct4", lat);

        bus.testing_sel = 3'd0;
        bus.training_sel = 3'd0;
        tick(3);
        buttons = oh(col(0));
        tick(8);
        reset = 1'b1;
        tick(1);
        chk("abort_rst_done", 4'(bus.input_done), 4'h0);
        chk("abort_rst_correct", 4'(bus.input_correct), 4'h0);
        chk("abort_rst_color", 4'(bus.train_color), 4'h0);
        buttons = 4'h0;
        reset = 1'b0;
        tick(3);
        chk("post_rst_done", 4'(bus.input_done), 4'h0);
        press(4'b0001, 1'b1, "after_rst", lat);
        bus.testing = 1'b0;
        tick(1);
        chk("abort_done", 4'(bus.input_done), 4'h0);
        chk("abort_correct", 4'(bus.input_correct), 4'h0);
        buttons = 4'b0100;
        tick(10);
        buttons = 4'h0;
        tick(20);
        chk("idle_press", 4'(bus.input_done), 4'h0);

        bus.gen = 1'b1;
        tick(3);
        bus.gen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.training_sel = 3'(i);
            exp_q.push_back(4'(col(i)));
            #1;
            check_next($sformatf("regen%0d", i), 4'(bus.train_color));
        end
        bus.testing = 1'b1;
        bus.testing_sel = 3'd2;
        tick(3);
        press(oh(col(2)), 1'b1, "final2", lat);
        bus.testing = 1'b0;
        tick(1);
        chk("final_drop", 4'(bus.input_done), 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/simon_input_checker.md
# simon_input_checker

Player-input side of the Simon game: stores the generated 5-colour sequence and judges button presses during testing. It consumes `gen`, `testing`, `testing_sel` and `training_sel` from the game state machine and returns the `input_done` / `input_correct` handshake. It also supplies the colour to display during training. It runs on the fast board clock and holds its result until the slow (2 Hz) state machine has consumed it.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: number of `base_clk` cycles a synchronized button vector must stay stable before it is accepted.
- `LFSR_SEED`, default 16'hACE1: reset value of the sequence LFSR; must be nonzero.

- `base_clk` input 1: board clock. Single clock domain.
- `reset` input 1: asynchronous, active-high. Clears all state.
- `gen` input 1: capture a new sequence.
- `training_sel` input 3: training step index, 0..4.
- `testing` input 1: the state machine is in a test step.
- `testing_sel` input 3: test step index, 0..4.
- `buttons` input 4: raw, asynchronous push-buttons; bit k = colour k.
- `train_color` output 2: stored colour at index `training_sel`.
- `input_done` output 1: a judged press is pending.
- `input_correct` output 1: the pending press matched. Valid only while `input_done` = 1.

## Operation
- **Button conditioning:** 2-FF synchronizer, then debounce. The debounced vector `db` updates only after the synchronized vector has been unchanged for `DEBOUNCE_CYCLES` consecutive cycles.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle. Reset value `LFSR_SEED`.
- **Sequence capture:** on every cycle with `gen` = 1, `seq[i] <= lfsr[2i+1:2i]` for i = 0..4. The last cycle of `gen` wins.
- **Training colour:** `train_color = seq[training_sel]` (combinational). Any index > 4 gives 0.
- **Checker FSM** (registered `cur_sel[2:0]`, `hit`):
  - IDLE: outputs low. On `testing` = 1: `cur_sel <= testing_sel`, go to ARM.
  - ARM: wait for `db` == 0 (a button already held does not count), then go to WAIT_PRESS.
  - WAIT_PRESS: on `db` != 0:
    - `hit <= 1` only if `db` is one-hot AND its index == `seq[cur_sel]` AND `cur_sel` <= 4; otherwise `hit <= 0`.
    - Go to WAIT_RELEASE.
  - WAIT_RELEASE: on `db` == 0, go to REPORT.
  - REPORT: `input_done` = 1, `input_correct` = `hit`. Hold until one of:
    - `testing_sel` != `cur_sel`: latch the new `cur_sel`, go to ARM.
    - `testing` = 0: go to IDLE.
  - `testing` = 0 in any state: go to IDLE on the next edge; `input_done` drops.
- `input_done` and `input_correct` are registered state-machine outputs; they are never asserted outside REPORT.

## Timing
- **Reset values:** `input_done` = 0, `input_correct` = 0, FSM = IDLE, `seq` = all 0, `lfsr` = `LFSR_SEED`, `db` = 0, debounce counter = 0. `train_color` = 0 while `seq` is 0.
- **Press latency:** a raw edge reaches `db` after 2 + `DEBOUNCE_CYCLES` cycles. Release of `db` raises `input_done` on the next edge.
- **Handshake:** `input_done` stays high until the state machine changes `testing_sel` or drops `testing`. This guarantees the 2 Hz sampler sees it. It falls 1 cycle after the change is seen.
- **Simultaneous events:**
  - `testing` falling takes priority over a select change.
  - `gen` concurrent with testing is not expected; if it happens, it still recaptures `seq`.
- **Reset mid-operation:** immediate return to reset values regardless of state.
- **Glitch rejection:** a bounce shorter than `DEBOUNCE_CYCLES` never reaches `db`.

## Test plan
Bench uses `DEBOUNCE_CYCLES` = 4 and `LFSR_SEED` = 16'hACE1.

1. **Reset:** assert `reset` with `buttons` = 4'b0010 held → all outputs 0. After release, no `input_done` while `testing` = 0.
2. **Capture:** pulse `gen` for 1 cycle, noting the predicted `lfsr` value at that edge. Step `training_sel` 0..4 → `train_color` equals each predicted 2-bit slice. `training_sel` = 5 → 0.
3. **Correct press:** `testing` = 1, `testing_sel` = 0; press the one-hot button for `seq[0]` for 10 cycles, then release → `input_done` = 1, `input_correct` = 1, held for 100 cycles. Set `testing_sel` = 1 → `input_done` = 0 one cycle later.
4. **Wrong press:** press a wrong colour → `input_done` = 1, `input_correct` = 0. Repeat with `buttons` = 4'b0011 → `input_correct` = 0.
5. **Debounce and carry-over:** a 2-cycle bounce produces no `input_done`. A button held across the `testing_sel` 1→2 change is ignored until it is released and pressed again.
6. **Abort:** assert `reset` during WAIT_RELEASE, then separately drop `testing` during REPORT → outputs 0 within 1 cycle and the FSM is in IDLE. A following correct press judges normally.
